// File: rtl/wb_uart_rx_fifo.sv
// Wishbone B4 classic UART receiver (8N1) with a byte FIFO and DATA/STATUS/CTRL registers.
// Define WB_UART_RX_PARITY_EN to receive 8E1 frames and report parity errors in STATUS[4].
`timescale 1ns/1ps
module wb_uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 24000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_AW     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        rx,
    output logic        irq_o,
    output logic [2:0]  rx_state
);
    localparam int DIVISOR = CLK_FREQ_HZ / BAUD;
    localparam int CW      = $clog2(DIVISOR);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam logic [CW-1:0]      HALF_M1  = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0]      FULL_M1  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0]      CNT_DEC  = CW'(1);
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shreg;
    logic                push_req, frame_set, parity_set;
    logic                rx_meta, rx_sync, rx_prev, rx_fall;
    logic                enable, irq_en, overrun, frame_err, parity_err;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                not_empty, full, pop, push_ok, overrun_set;
    logic                bus_req, reg_wr;
    logic [31:0]         status, rdata;
    logic                unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_dat_i[31:4], wb_adr_i[1:0]};
    assign rx_state    = state;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end
    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            push_req   <= 1'b0;
            frame_set  <= 1'b0;
            parity_set <= 1'b0;
        end else begin
            push_req   <= 1'b0;
            frame_set  <= 1'b0;
            parity_set <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (rx_fall) begin
                        state <= S_START;
                        cnt   <= HALF_M1;
                    end
                    S_START: if (cnt == '0) begin
                        if (!rx_sync) begin
                            state   <= S_DATA;
                            cnt     <= FULL_M1;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else cnt <= cnt - CNT_DEC;
                    S_DATA: if (cnt == '0) begin
                        shreg <= {rx_sync, shreg[7:1]};
                        cnt   <= FULL_M1;
                        if (bit_idx == 3'd7) begin
`ifdef WB_UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else cnt <= cnt - CNT_DEC;
`ifdef WB_UART_RX_PARITY_EN
                    S_PARITY: if (cnt == '0) begin
                        cnt <= FULL_M1;
                        if ((^shreg) ^ rx_sync) begin
                            parity_set <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_STOP;
                        end
                    end else cnt <= cnt - CNT_DEC;
`endif
                    S_STOP: if (cnt == '0) begin
                        state <= S_IDLE;
                        if (rx_sync) push_req  <= 1'b1;
                        else         frame_set <= 1'b1;
                    end else cnt <= cnt - CNT_DEC;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus_req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_wr      = bus_req & wb_we_i;
    assign not_empty   = (count != '0);
    assign full        = (count == DEPTH_C);
    assign pop         = bus_req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0) & not_empty;
    // A push at full is still accepted when a pop frees the slot in the same cycle.
    assign push_ok     = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        status                 = '0;
        status[0]              = not_empty;
        status[1]              = full;
        status[2]              = overrun;
        status[3]              = frame_err;
        status[4]              = parity_err;
        status[8+FIFO_AW:8]    = count;
    end

    always_comb begin
        rdata = '0;
        case (wb_adr_i[3:2])
            2'd0:    if (not_empty) rdata[7:0] = mem[rd_ptr];
            2'd1:    rdata = status;
            2'd2:    rdata[1:0] = {irq_en, enable};
            default: rdata = '0;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            irq_o     <= 1'b0;
            enable    <= 1'b1;
            irq_en    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wb_ack_o <= bus_req;
            wb_dat_o <= (bus_req && !wb_we_i) ? rdata : '0;
            irq_o    <= irq_en & (not_empty | overrun | frame_err | parity_err);
            if (reg_wr && wb_adr_i[3:2] == 2'd2) begin
                enable <= wb_dat_i[0];
                irq_en <= wb_dat_i[1];
            end
            if (overrun_set)                                           overrun <= 1'b1;
            else if (reg_wr && wb_adr_i[3:2] == 2'd1 && wb_dat_i[2])   overrun <= 1'b0;
            if (frame_set)                                             frame_err <= 1'b1;
            else if (reg_wr && wb_adr_i[3:2] == 2'd1 && wb_dat_i[3])   frame_err <= 1'b0;
        end
    end

`ifdef WB_UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (parity_set) begin
            parity_err <= 1'b1;
        end else if (reg_wr && wb_adr_i[3:2] == 2'd1 && wb_dat_i[4]) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_uart_rx_fifo.sv
// Directed bench for wb_uart_rx_fifo at DIVISOR=16: bus registers, FIFO order, error flags,
// glitch/abort/reset handling and a pop that coincides with a push at full.
`timescale 1ns/1ps
module tb_wb_uart_rx_fifo;
    localparam int DIV = 16;
`ifdef WB_UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Negedges from fork start until the bus request that lands on the push edge.
    localparam int POP_LEAD = DIV * (NBITS - 1) + 11;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        rx = 1'b1;
    logic        irq_o;
    logic [2:0]  rx_state;

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rd;

    wb_uart_rx_fifo #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .FIFO_AW(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .rx(rx), .irq_o(irq_o), .rx_state(rx_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic [3:0] a, input logic [31:0] d, input logic we,
                           output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = '0;
        @(negedge clock);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clock); #1;
            if (wb_ack_o) begin
                got = 1'b1;
                q = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) check_eq("wb_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(a, d, 1'b1, dummy);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
        wb_xfer(a, 32'd0, 1'b0, q);
    endtask

    // par_ok=1 sends the correct even-parity bit (8E1 builds only).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_ok);
        @(negedge clock);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (DIV) @(negedge clock);
        end
`ifdef WB_UART_RX_PARITY_EN
        rx = (^data) ^ ~par_ok;
        repeat (DIV) @(negedge clock);
`else
        if (par_ok) rx = 1'b1;
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic read_data_expect(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        wb_read(4'h0, rd);
        check_eq(tag, rd, {24'd0, e});
    endtask

    initial begin
        repeat (4) @(negedge clock);
        check_eq("reset_ack", {31'd0, wb_ack_o}, 32'd0);
        check_eq("reset_irq", {31'd0, irq_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("reset_dat", wb_dat_o, 32'd0);
        check_eq("reset_state", {29'd0, rx_state}, 32'd0);
        wb_read(4'h4, rd); check_eq("reset_status", rd, 32'h000);
        wb_read(4'h8, rd); check_eq("reset_ctrl", rd, 32'h001);
        wb_write(4'hC, 32'hFFFF_FFFF);
        wb_read(4'hC, rd); check_eq("reg_c_zero", rd, 32'h0);

        // Single byte round trip.
        send_frame(8'hA5, 1'b1, 1'b1); exp_q.push_back(8'hA5);
        wb_read(4'h4, rd); check_eq("a5_status", rd, 32'h101);
        read_data_expect("a5_data");
        wb_read(4'h4, rd); check_eq("a5_status_empty", rd, 32'h000);
        wb_read(4'h0, rd); check_eq("empty_data", rd, 32'h0);

        // Nine bytes into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            if (i < 8) exp_q.push_back(8'(i));
        end
        wb_read(4'h4, rd); check_eq("overrun_status", rd, 32'h807);
        for (int i = 0; i < 8; i++) read_data_expect($sformatf("fill_data_%0d", i));
        wb_read(4'h4, rd); check_eq("drained_status", rd, 32'h004);
        wb_write(4'h4, 32'h4);
        wb_read(4'h4, rd); check_eq("overrun_cleared", rd, 32'h000);

        // Frame error with interrupt enabled.
        wb_write(4'h8, 32'h3);
        wb_read(4'h8, rd); check_eq("ctrl_irq_en", rd, 32'h003);
        check_eq("irq_idle", {31'd0, irq_o}, 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wb_read(4'h4, rd); check_eq("frame_err_status", rd, 32'h008);
        check_eq("frame_err_irq", {31'd0, irq_o}, 32'd1);
        wb_write(4'h4, 32'h8);
        wb_read(4'h4, rd); check_eq("frame_err_cleared", rd, 32'h000);
        repeat (2) @(negedge clock);
        check_eq("irq_cleared", {31'd0, irq_o}, 32'd0);
        wb_write(4'h8, 32'h1);

        // Short glitch on the line.
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("glitch_in_start", {29'd0, rx_state}, 32'd1);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        check_eq("glitch_back_idle", {29'd0, rx_state}, 32'd0);
        wb_read(4'h4, rd); check_eq("glitch_status", rd, 32'h000);

        // Disable mid-frame aborts reception.
        @(negedge clock);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        rx = 1'b1;
        repeat (12) @(negedge clock);
        check_eq("abort_in_data", {29'd0, rx_state}, 32'd2);
        wb_write(4'h8, 32'h0);
        @(posedge clock); #1;
        check_eq("abort_idle", {29'd0, rx_state}, 32'd0);
        repeat (10 * DIV) @(negedge clock);
        wb_write(4'h8, 32'h1);
        wb_read(4'h4, rd); check_eq("abort_status", rd, 32'h000);

        // Pop coincides with a push while full.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
            exp_q.push_back(8'h10 + 8'(i));
        end
        wb_read(4'h4, rd); check_eq("full_status", rd, 32'h803);
        @(negedge clock);
        fork
            send_frame(8'h99, 1'b1, 1'b1);
            begin
                repeat (POP_LEAD) @(negedge clock);
                read_data_expect("coincident_pop");
            end
        join
        exp_q.push_back(8'h99);
        wb_read(4'h4, rd); check_eq("coincident_status", rd, 32'h803);
        for (int i = 0; i < 8; i++) read_data_expect($sformatf("after_full_%0d", i));
        wb_read(4'h4, rd); check_eq("after_full_status", rd, 32'h000);

`ifdef WB_UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        wb_read(4'h4, rd); check_eq("parity_err_status", rd, 32'h010);
        send_frame(8'h01, 1'b1, 1'b1); exp_q.push_back(8'h01);
        wb_read(4'h4, rd); check_eq("parity_ok_status", rd, 32'h111);
        read_data_expect("parity_ok_data");
        wb_write(4'h4, 32'h10);
        wb_read(4'h4, rd); check_eq("parity_cleared", rd, 32'h000);
`endif

        // Reset in the middle of a frame with a byte buffered.
        send_frame(8'h5A, 1'b1, 1'b1);
        wb_write(4'h8, 32'h3);
        @(negedge clock);
        rx = 1'b0;
        repeat (40) @(negedge clock);
        check_eq("pre_reset_data_state", {29'd0, rx_state}, 32'd2);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("in_reset_state", {29'd0, rx_state}, 32'd0);
        check_eq("in_reset_irq", {31'd0, irq_o}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_eq("post_reset_state", {29'd0, rx_state}, 32'd0);
        wb_read(4'h4, rd); check_eq("post_reset_status", rd, 32'h000);
        wb_read(4'h8, rd); check_eq("post_reset_ctrl", rd, 32'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/wb_uart_rx_fifo.md
# wb_uart_rx_fifo

Wishbone B4 classic responder that receives 8N1 serial frames on an asynchronous RX line, buffers the bytes in a FIFO, and exposes them to the PicoRV32 Wishbone SoC through DATA, STATUS and CTRL registers. It is the receiving end of the board UART link: the SoC's `uart_tx` (IO[5]) or an external host drives its `rx` input. It runs in the 24 MHz `wb_clk` domain generated by the board clock generator.

## Interface
- `CLK_FREQ_HZ`, 24000000, clock frequency.
- `BAUD`, 115200, line rate; bit period `DIVISOR = CLK_FREQ_HZ / BAUD` (integer division, 208 at defaults, must be ≥ 4).
- `FIFO_AW`, 3, FIFO depth is `2**FIFO_AW` (8).
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: **asynchronous, active-low reset.**
- `wb_adr_i` in 4: byte address; bits [3:2] select the register.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte selects; ignored (full-word registers).
- `wb_we_i` in 1: write enable.
- `wb_cyc_i`, `wb_stb_i` in 1: bus cycle and strobe.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` out 1: transfer acknowledge.
- `rx` in 1: serial input, idle high.
- `irq_o` out 1: interrupt request.

## Operation
- Registers:
  - 0x0 DATA (R): bits [7:0] = FIFO head. A read pops the FIFO. An empty read returns 0 and does not pop.
  - 0x4 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [4] parity_err (sticky, macro only), [8+FIFO_AW:8] count. Writing 1 to a sticky bit clears it.
  - 0x8 CTRL (R/W): [0] enable (reset 1), [1] irq_en (reset 0).
  - 0xC: reads 0; writes are ignored.
- `irq_o` = irq_en & (not_empty | overrun | frame_err); registered.
- `rx` passes through a 2-flop synchronizer and is then edge-detected.
- Receiver FSM:
  - IDLE: on a synced falling edge with enable=1 → START; counter = DIVISOR/2.
  - START: when the counter expires, re-sample. If low → DATA with counter = DIVISOR and bit index 0. If high, it is a glitch → IDLE.
  - DATA: sample at each counter expiry, LSB first. After bit 7 → PARITY (macro) or STOP.
  - STOP: sample. If high, push the byte. If low, set frame_err and discard the byte. Either way → IDLE, where a new start requires a new falling edge.
- Clearing enable forces the FSM to IDLE in the next cycle and aborts any partial frame. The FIFO contents are kept.
- Push while full with no simultaneous pop: drop the byte and set overrun.
- Push and pop in the same cycle: both take effect and the count is unchanged. This holds at full, where the push is accepted, and at empty+push, where the pop is ignored because the FIFO was empty.
- Count width is FIFO_AW+1. Pointers wrap modulo the depth.

## Timing
- All outputs reset to 0 except internal CTRL.enable = 1. FIFO becomes empty, FSM goes to IDLE, sticky bits clear.
- Bus: `wb_ack_o` rises the cycle after `wb_cyc_i & wb_stb_i & !wb_ack_o` is sampled, and stays high for exactly 1 cycle. Back-to-back strobes are therefore acked every other cycle.
- Register writes and the DATA pop take effect on the ack cycle edge. `wb_dat_o` is registered alongside the ack.
- A pushed byte is visible in STATUS.not_empty 1 cycle after the stop-bit sample.
- Line-to-sample latency is 2 cycles (synchronizer). Each data bit is sampled DIVISOR/2 + k·DIVISOR cycles after the detected edge.
- Deasserting `reset_n` mid-frame drops the frame. The first cycle after release is IDLE.

## Configuration
- `WB_UART_RX_PARITY_EN` defined: the frame becomes 8E1. The PARITY state samples one extra bit. If the XOR of the data bits and the parity bit is 1, the byte is discarded and STATUS[4] is set; otherwise → STOP. parity_err also contributes to `irq_o`.
- Not defined: 8N1 only. STATUS[4] reads 0.

## Test plan
- Use CLK_FREQ_HZ=1600000, BAUD=100000 (DIVISOR=16).
- Send frame 0xA5 → STATUS reads 0x101. A DATA read returns 0xA5. STATUS then reads 0x000.
- Send 9 bytes 0x00..0x08 without reading → STATUS full=1, overrun=1, count=8. Reads return 0x00..0x07. Write STATUS=0x4 → overrun clears.
- Send 0x3C with the stop bit driven low → no push, frame_err=1. With irq_en=1, `irq_o`=1. Writing 0x8 clears it.
- Drive a 4-cycle low glitch on `rx` → FSM returns to IDLE, count stays 0. Then clear enable mid-frame → no byte is pushed.
- With FIFO full at 8, a DATA read lands in the same cycle as a push → count stays 8, no overrun, and the 8th read returns the new byte.
- With `WB_UART_RX_PARITY_EN` defined, send 0x01 with parity bit 0 → parity_err=1 and no push. Send 0x01 with parity bit 1 → byte pushed.
